branch_control: RTL and testbench

- Branch comparator and resolver for the RV32I core execute stage.
- Combinationally compares rs1/rs2 and produces equal / less-than flags, with signed or unsigned mode selected by funct3, plus a decoded branch-taken decision.
- A small clocked section registers the resolved decision for the next stage and keeps branch statistics counters.

---
 rtl/rv_pkg.sv | 16 +
 rtl/branch_control_if.sv | 30 +++
 rtl/br_compare.sv | 23 ++
 rtl/branch_control.sv | 83 ++++++++
 tb/tb_branch_control.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I constants for the execute-stage branch logic.
// Contents: BRANCH opcode, branch funct3 encodings, default operand width.
package rv_pkg;

    localparam int unsigned DWIDTH_DEFAULT = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_control_if.sv
// Branch-control bus: instruction fields and operands in, flags and statistics out.
// master : driver side (execute stage / bench) - drives opcode, funct3, operands, en.
// slave  : branch_control side - consumes those, drives the flags and counters.
interface branch_control_if #(
    parameter int unsigned DWIDTH = rv_pkg::DWIDTH_DEFAULT,
    parameter int unsigned CWIDTH = 32
);
    logic [6:0]        opcode_i;
    logic [2:0]        funct3_i;
    logic [DWIDTH-1:0] rs1_i;
    logic [DWIDTH-1:0] rs2_i;
    logic              en_i;
    logic              breq_o;
    logic              brlt_o;
    logic              taken_o;
    logic              illegal_o;
    logic              taken_q_o;
    logic [CWIDTH-1:0] br_cnt_o;
    logic [CWIDTH-1:0] taken_cnt_o;

    modport master (
        output opcode_i, funct3_i, rs1_i, rs2_i, en_i,
        input  breq_o, brlt_o, taken_o, illegal_o, taken_q_o, br_cnt_o, taken_cnt_o
    );

    modport slave (
        input  opcode_i, funct3_i, rs1_i, rs2_i, en_i,
        output breq_o, brlt_o, taken_o, illegal_o, taken_q_o, br_cnt_o, taken_cnt_o
    );
endinterface

// File: rtl/br_compare.sv
// Purely combinational operand comparator.
// a, b       : operands
// unsigned_i : 1 = unsigned compare, 0 = signed two's-complement compare
// eq         : a == b
// lt         : a < b in the selected mode
module br_compare #(
    parameter int unsigned DWIDTH = rv_pkg::DWIDTH_DEFAULT
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic              unsigned_i,
    output logic              eq,
    output logic              lt
);
    always_comb begin
        eq = (a == b);
        if (unsigned_i) begin
            lt = (a < b);
        end else begin
            lt = ($signed(a) < $signed(b));
        end
    end
endmodule

// File: rtl/branch_control.sv
// Branch comparator/resolver for the RV32I execute stage.
// clk, reset : clock and asynchronous active-high reset for the registered section
// bus (slave): opcode/funct3/rs1/rs2/en in; breq/brlt/taken/illegal (combinational),
//              taken_q (registered decision), br_cnt/taken_cnt (wrapping statistics) out.
module branch_control
    import rv_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEFAULT,
    parameter int unsigned CWIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    branch_control_if.slave  bus
);
    logic              is_br;
    logic              cmp_eq;
    logic              cmp_lt;
    logic              taken;
    logic              illegal;

    logic              taken_q, taken_d;
    logic [CWIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [CWIDTH-1:0] taken_cnt_q, taken_cnt_d;

    // funct3[1] selects unsigned mode (BLTU/BGEU); BEQ/BNE fall into signed mode.
    br_compare #(
        .DWIDTH (DWIDTH)
    ) u_cmp (
        .a          (bus.rs1_i),
        .b          (bus.rs2_i),
        .unsigned_i (bus.funct3_i[1]),
        .eq         (cmp_eq),
        .lt         (cmp_lt)
    );

    always_comb begin
        is_br   = (bus.opcode_i == OPC_BRANCH);
        illegal = 1'b0;
        taken   = 1'b0;
        unique case (bus.funct3_i)
            F3_BEQ:             taken = cmp_eq;
            F3_BNE:             taken = !cmp_eq;
            F3_BLT,  F3_BLTU:   taken = cmp_lt;
            F3_BGE,  F3_BGEU:   taken = !cmp_lt;
            default:            illegal = 1'b1;
        endcase
        // Everything is qualified by the opcode so non-branches report all-zero.
        illegal = illegal & is_br;
        taken   = taken & is_br;
    end

    always_comb begin
        taken_d     = bus.en_i & taken;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (bus.en_i && is_br && !illegal) begin
            br_cnt_d = br_cnt_q + 1'b1;
            if (taken) begin
                taken_cnt_d = taken_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_q     <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            taken_q     <= taken_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign bus.breq_o      = is_br & cmp_eq;
    assign bus.brlt_o      = is_br & cmp_lt;
    assign bus.taken_o     = taken;
    assign bus.illegal_o   = illegal;
    assign bus.taken_q_o   = taken_q;
    assign bus.br_cnt_o    = br_cnt_q;
    assign bus.taken_cnt_o = taken_cnt_q;
endmodule

// File: tb/tb_branch_control.sv
// Directed + table-driven bench for branch_control.
module tb_branch_control;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 32;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] ALU = 7'b0110011;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    branch_control_if #(.DWIDTH(DW), .CWIDTH(CW)) bus ();

    branch_control #(.DWIDTH(DW), .CWIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        eq;
        logic        lt;
        logic        tk;
        logic        il;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic en);
        bus.opcode_i = opc;
        bus.funct3_i = f3;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.en_i     = en;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        logic        exp_lt;
        errors = 0;
        checks = 0;

        //          opc  f3      a             b             eq   lt   tk   il
        vecs[0]  = '{BR,  3'b000, 32'd5,        32'd5,        1'b1,1'b0,1'b1,1'b0};
        vecs[1]  = '{BR,  3'b000, 32'd5,        32'd7,        1'b0,1'b1,1'b0,1'b0};
        vecs[2]  = '{BR,  3'b001, 32'd5,        32'd7,        1'b0,1'b1,1'b1,1'b0};
        vecs[3]  = '{BR,  3'b100, 32'hFFFFFFFF, 32'd1,        1'b0,1'b1,1'b1,1'b0};
        vecs[4]  = '{BR,  3'b100, 32'h80000000, 32'h7FFFFFFF, 1'b0,1'b1,1'b1,1'b0};
        vecs[5]  = '{BR,  3'b101, 32'h80000000, 32'h7FFFFFFF, 1'b0,1'b1,1'b0,1'b0};
        vecs[6]  = '{BR,  3'b110, 32'hFFFFFFFF, 32'd0,        1'b0,1'b0,1'b0,1'b0};
        vecs[7]  = '{BR,  3'b110, 32'd0,        32'd1,        1'b0,1'b1,1'b1,1'b0};
        vecs[8]  = '{BR,  3'b111, 32'd0,        32'd1,        1'b0,1'b1,1'b0,1'b0};
        vecs[9]  = '{BR,  3'b111, 32'hFFFFFFFF, 32'd0,        1'b0,1'b0,1'b1,1'b0};
        vecs[10] = '{BR,  3'b010, 32'd3,        32'd3,        1'b1,1'b0,1'b0,1'b1};
        vecs[11] = '{BR,  3'b011, 32'd9,        32'd2,        1'b0,1'b0,1'b0,1'b1};
        vecs[12] = '{ALU, 3'b000, 32'd5,        32'd5,        1'b0,1'b0,1'b0,1'b0};
        vecs[13] = '{BR,  3'b101, 32'd4,        32'd4,        1'b1,1'b0,1'b1,1'b0};

        drive(ALU, 3'b000, '0, '0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_taken_q", {31'd0, bus.taken_q_o}, 32'd0);
        chk("reset_br_cnt", bus.br_cnt_o, 32'd0);
        chk("reset_taken_cnt", bus.taken_cnt_o, 32'd0);
        // combinational path is independent of reset
        drive(BR, 3'b000, 32'd5, 32'd5, 1'b0);
        #1;
        chk("comb_in_reset_taken", {31'd0, bus.taken_o}, 32'd1);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].opc, vecs[i].f3, vecs[i].a, vecs[i].b, 1'b0);
            #1;
            chk($sformatf("v%0d_breq", i),    {31'd0, bus.breq_o},    {31'd0, vecs[i].eq});
            chk($sformatf("v%0d_brlt", i),    {31'd0, bus.brlt_o},    {31'd0, vecs[i].lt});
            chk($sformatf("v%0d_taken", i),   {31'd0, bus.taken_o},   {31'd0, vecs[i].tk});
            chk($sformatf("v%0d_illegal", i), {31'd0, bus.illegal_o}, {31'd0, vecs[i].il});
        end

        for (int n = 0; n < 200; n++) begin
            ra = $urandom;
            rb = (n % 10 == 0) ? ra : $urandom;
            rf = ($urandom_range(0, 1) == 1) ? 3'b110 : 3'b100;
            if (n % 7 == 0) ra = {1'b1, ra[30:0]};
            drive(BR, rf, ra, rb, 1'b0);
            #1;
            exp_lt = (rf == 3'b110) ? (ra < rb) : ($signed(ra) < $signed(rb));
            chk($sformatf("rnd%0d_brlt", n), {31'd0, bus.brlt_o}, {31'd0, exp_lt});
            chk($sformatf("rnd%0d_breq", n), {31'd0, bus.breq_o}, {31'd0, ra == rb});
            chk($sformatf("rnd%0d_taken", n), {31'd0, bus.taken_o}, {31'd0, exp_lt});
        end

        // counters: taken, not-taken, taken, then en_i low
        @(negedge clk);
        chk("idle_br_cnt", bus.br_cnt_o, 32'd0);
        drive(BR, 3'b000, 32'd5, 32'd5, 1'b1);
        @(negedge clk);
        chk("seq1_taken_q", {31'd0, bus.taken_q_o}, 32'd1);
        chk("seq1_br_cnt", bus.br_cnt_o, 32'd1);
        drive(BR, 3'b000, 32'd5, 32'd7, 1'b1);
        @(negedge clk);
        chk("seq2_taken_q", {31'd0, bus.taken_q_o}, 32'd0);
        chk("seq2_taken_cnt", bus.taken_cnt_o, 32'd1);
        drive(BR, 3'b110, 32'd0, 32'd1, 1'b1);
        @(negedge clk);
        drive(BR, 3'b000, 32'd5, 32'd5, 1'b0);
        @(negedge clk);
        chk("seq_taken_q_en0", {31'd0, bus.taken_q_o}, 32'd0);
        chk("seq_br_cnt", bus.br_cnt_o, 32'd3);
        chk("seq_taken_cnt", bus.taken_cnt_o, 32'd2);
        // illegal and non-branch valid instructions do not count
        drive(BR, 3'b010, 32'd1, 32'd1, 1'b1);
        @(negedge clk);
        drive(ALU, 3'b000, 32'd1, 32'd1, 1'b1);
        @(negedge clk);
        chk("illegal_no_count", bus.br_cnt_o, 32'd3);
        chk("illegal_no_taken", bus.taken_cnt_o, 32'd2);

        // asynchronous reset away from any clock edge
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_br_cnt", bus.br_cnt_o, 32'd0);
        chk("async_rst_taken_cnt", bus.taken_cnt_o, 32'd0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
